// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: FSM state encoding, source IDs and frame defaults.
// Used by the TX arbiter and by the frame generators that sit in front of it.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_XFER  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAP   = 3'd4
  } eth_state_e;

  typedef enum logic {
    SRC_ARP = 1'b0,
    SRC_UDP = 1'b1
  } eth_src_e;

  localparam int ETH_IFG           = 12;
  localparam int ETH_MAX_FRAME     = 1526;
  localparam int ETH_START_TIMEOUT = 64;

  // On a tie the source that did not win last time is chosen.
  function automatic eth_src_e rr_pick(input logic arp_req, input logic udp_req,
                                       input eth_src_e last_winner);
    eth_src_e pick;
    if (arp_req && udp_req) begin
      pick = (last_winner == SRC_UDP) ? SRC_ARP : SRC_UDP;
    end else if (arp_req) begin
      pick = SRC_ARP;
    end else if (udp_req) begin
      pick = SRC_UDP;
    end else begin
      pick = last_winner;
    end
    return pick;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker; remembers the last winner so ties alternate.
// The winner register only moves when the caller commits a grant via i_take.
module arb_rr2 import eth_pkg::*; (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_arp_req,
  input  logic     i_udp_req,
  input  logic     i_take,
  output eth_src_e o_pick,
  output logic     o_valid
);

  eth_src_e r_last;

  // Last-winner register; UDP after reset so ARP wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= SRC_UDP;
    end else if (i_take) begin
      r_last <= o_pick;
    end else begin
      r_last <= r_last;
    end
  end

  assign o_pick  = rr_pick(i_arp_req, i_udp_req, r_last);
  assign o_valid = i_arp_req | i_udp_req;

endmodule

// File: rtl/eth_tx_arbiter.sv
// Shares the GMII TX byte path between ARP and UDP sources: one grant per frame,
// registered byte forwarding, inter-frame gap, start timeout and length truncation.
module eth_tx_arbiter import eth_pkg::*; #(
  parameter int IFG_CYCLES    = ETH_IFG,
  parameter int START_TIMEOUT = ETH_START_TIMEOUT,
  parameter int MAX_LEN       = ETH_MAX_FRAME
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_arp_req,
  output logic        o_arp_gnt,
  input  logic [7:0]  i_arp_data,
  input  logic        i_arp_vl,
  input  logic        i_udp_req,
  output logic        o_udp_gnt,
  input  logic [7:0]  i_udp_data,
  input  logic        i_udp_vl,
  output logic [7:0]  o_data,
  output logic        o_tx_en,
  output logic        o_busy,
  output logic        o_err_timeout,
  output logic        o_err_len,
  output logic [15:0] o_pkt_cnt
);

  localparam int BYTE_W = $clog2(MAX_LEN + 1);
  localparam int WAIT_W = $clog2(START_TIMEOUT + 1);
  localparam int GAP_W  = $clog2(IFG_CYCLES + 1);

  eth_state_e        r_state;
  eth_src_e          r_src;
  logic [7:0]        r_data;
  logic              r_tx_en;
  logic              r_arp_gnt;
  logic              r_udp_gnt;
  logic              r_busy;
  logic              r_err_timeout;
  logic              r_err_len;
  logic [15:0]       r_pkt_cnt;
  logic [BYTE_W-1:0] r_byte_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;

  eth_state_e        w_state_nxt;
  eth_src_e          w_src_nxt;
  eth_src_e          w_pick;
  logic              w_arb_valid;
  logic              w_take;
  logic [7:0]        w_data_nxt;
  logic              w_tx_en_nxt;
  logic              w_gnt_nxt;
  logic              w_err_timeout_nxt;
  logic              w_err_len_nxt;
  logic [15:0]       w_pkt_cnt_nxt;
  logic [BYTE_W-1:0] w_byte_cnt_nxt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic [GAP_W-1:0]  w_gap_cnt_nxt;
  logic              w_req;
  logic              w_vl;
  logic [7:0]        w_din;

  arb_rr2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_arp_req (i_arp_req),
    .i_udp_req (i_udp_req),
    .i_take    (w_take),
    .o_pick    (w_pick),
    .o_valid   (w_arb_valid)
  );

  // Only the granted source is ever looked at.
  assign w_req = (r_src == SRC_ARP) ? i_arp_req  : i_udp_req;
  assign w_vl  = (r_src == SRC_ARP) ? i_arp_vl   : i_udp_vl;
  assign w_din = (r_src == SRC_ARP) ? i_arp_data : i_udp_data;

  // Next-state, next-output and counter logic for the frame FSM.
  always_comb begin
    w_state_nxt       = r_state;
    w_src_nxt         = r_src;
    w_take            = 1'b0;
    w_data_nxt        = 8'h00;
    w_tx_en_nxt       = 1'b0;
    w_err_timeout_nxt = 1'b0;
    w_err_len_nxt     = 1'b0;
    w_pkt_cnt_nxt     = r_pkt_cnt;
    w_byte_cnt_nxt    = r_byte_cnt;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_gap_cnt_nxt     = r_gap_cnt;
    case (r_state)
      ST_IDLE: begin
        w_wait_cnt_nxt = WAIT_W'(0);
        w_byte_cnt_nxt = BYTE_W'(0);
        w_gap_cnt_nxt  = GAP_W'(0);
        if (w_arb_valid) begin
          w_state_nxt = ST_GRANT;
          w_src_nxt   = w_pick;
          w_take      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (w_vl) begin
          w_state_nxt    = ST_XFER;
          w_data_nxt     = w_din;
          w_tx_en_nxt    = 1'b1;
          w_byte_cnt_nxt = BYTE_W'(1);
        end else if (!w_req) begin
          w_state_nxt = ST_IDLE;
        end else if (r_wait_cnt == WAIT_W'(START_TIMEOUT - 1)) begin
          w_state_nxt       = ST_GAP;
          w_err_timeout_nxt = 1'b1;
          w_gap_cnt_nxt     = GAP_W'(0);
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
      ST_XFER: begin
        if (!w_vl) begin
          w_state_nxt   = ST_GAP;
          w_pkt_cnt_nxt = r_pkt_cnt + 16'd1;
          w_gap_cnt_nxt = GAP_W'(0);
        end else if (r_byte_cnt == BYTE_W'(MAX_LEN)) begin
          // MAX_LEN bytes already out: drop the rest of this frame.
          w_state_nxt   = ST_DRAIN;
          w_err_len_nxt = 1'b1;
        end else begin
          w_data_nxt     = w_din;
          w_tx_en_nxt    = 1'b1;
          w_byte_cnt_nxt = r_byte_cnt + BYTE_W'(1);
        end
      end
      ST_DRAIN: begin
        if (!w_vl) begin
          w_state_nxt   = ST_GAP;
          w_gap_cnt_nxt = GAP_W'(0);
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_W'(IFG_CYCLES - 1)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_gnt_nxt = (w_state_nxt == ST_GRANT) || (w_state_nxt == ST_XFER) ||
                (w_state_nxt == ST_DRAIN);
  end

  // State, counters and all outputs registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_src         <= SRC_ARP;
      r_data        <= 8'h00;
      r_tx_en       <= 1'b0;
      r_arp_gnt     <= 1'b0;
      r_udp_gnt     <= 1'b0;
      r_busy        <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_len     <= 1'b0;
      r_pkt_cnt     <= 16'd0;
      r_byte_cnt    <= BYTE_W'(0);
      r_wait_cnt    <= WAIT_W'(0);
      r_gap_cnt     <= GAP_W'(0);
    end else begin
      r_state       <= w_state_nxt;
      r_src         <= w_src_nxt;
      r_data        <= w_data_nxt;
      r_tx_en       <= w_tx_en_nxt;
      r_arp_gnt     <= w_gnt_nxt && (w_src_nxt == SRC_ARP);
      r_udp_gnt     <= w_gnt_nxt && (w_src_nxt == SRC_UDP);
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_err_timeout <= w_err_timeout_nxt;
      r_err_len     <= w_err_len_nxt;
      r_pkt_cnt     <= w_pkt_cnt_nxt;
      r_byte_cnt    <= w_byte_cnt_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_gap_cnt     <= w_gap_cnt_nxt;
    end
  end

  assign o_arp_gnt     = r_arp_gnt;
  assign o_udp_gnt     = r_udp_gnt;
  assign o_data        = r_data;
  assign o_tx_en       = r_tx_en;
  assign o_busy        = r_busy;
  assign o_err_timeout = r_err_timeout;
  assign o_err_len     = r_err_len;
  assign o_pkt_cnt     = r_pkt_cnt;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter: stimulus queues expected bytes, a forked
// monitor pops them whenever o_tx_en is high and tracks frame lengths and error pulses.
module tb_eth_tx_arbiter;

  localparam int MAXL = 1526;

  logic        clk = 1'b0;
  logic        rst;
  logic        arp_req, arp_vl, udp_req, udp_vl;
  logic [7:0]  arp_data, udp_data;
  logic        o_arp_gnt, o_udp_gnt, o_tx_en, o_busy, o_err_timeout, o_err_len;
  logic [7:0]  o_data;
  logic [15:0] o_pkt_cnt;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int         run_len = 0;
  int         last_run = 0;
  int         n_to = 0;
  int         n_len = 0;

  always #5 clk = ~clk;

  eth_tx_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .i_arp_req     (arp_req),
    .o_arp_gnt     (o_arp_gnt),
    .i_arp_data    (arp_data),
    .i_arp_vl      (arp_vl),
    .i_udp_req     (udp_req),
    .o_udp_gnt     (o_udp_gnt),
    .i_udp_data    (udp_data),
    .i_udp_vl      (udp_vl),
    .o_data        (o_data),
    .o_tx_en       (o_tx_en),
    .o_busy        (o_busy),
    .o_err_timeout (o_err_timeout),
    .o_err_len     (o_err_len),
    .o_pkt_cnt     (o_pkt_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output int src);
    src = -1;
    for (int i = 0; i < 400 && src < 0; i++) begin
      tick();
      if (o_arp_gnt) src = 0;
      else if (o_udp_gnt) src = 1;
    end
    if (src < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_gnt: no grant within 400 cycles");
    end
  endtask

  // Drives n bytes (base+i) as one frame from src; bytes past MAXL are not expected on the wire.
  task automatic send_frame(input int src, input int n, input int base);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'(base + i);
      if (src == 0) begin arp_vl = 1'b1; arp_data = b; end
      else begin udp_vl = 1'b1; udp_data = b; end
      if (i < MAXL) exp_q.push_back(b);
      tick();
      if (i == 0) begin
        chk("first_byte_tx_en", int'(o_tx_en), 1);
        chk("first_byte_data", int'(o_data), int'(b));
      end
    end
    arp_vl = 1'b0; arp_data = 8'h00;
    udp_vl = 1'b0; udp_data = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    arp_req = 1'b0; arp_vl = 1'b0; arp_data = 8'h00;
    udp_req = 1'b0; udp_vl = 1'b0; udp_data = 8'h00;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int src, cnt, to0, len0, pkt0;
    rst = 1'b1;
    arp_req = 1'b0; arp_vl = 1'b0; arp_data = 8'h00;
    udp_req = 1'b0; udp_vl = 1'b0; udp_data = 8'h00;
    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          exp_q.delete();
          run_len = 0;
        end else begin
          chk("gnt_onehot", int'(o_arp_gnt && o_udp_gnt), 0);
          if (o_tx_en) begin
            run_len++;
            if (exp_q.size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL unexpected_byte: got 0x%02h with empty scoreboard", o_data);
            end else begin
              mon_exp = exp_q.pop_front();
              chk("tx_byte", int'(o_data), int'(mon_exp));
            end
          end else begin
            if (run_len > 0) begin
              last_run = run_len;
              run_len = 0;
            end
            chk("idle_data_zero", int'(o_data), 0);
          end
          if (o_err_timeout) n_to++;
          if (o_err_len) n_len++;
        end
      end
      begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset values
    repeat (2) tick();
    chk("rst_arp_gnt", int'(o_arp_gnt), 0);
    chk("rst_udp_gnt", int'(o_udp_gnt), 0);
    chk("rst_tx_en", int'(o_tx_en), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_pkt_cnt", int'(o_pkt_cnt), 0);
    chk("rst_err_to", int'(o_err_timeout), 0);
    chk("rst_err_len", int'(o_err_len), 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", int'(o_busy), 0);

    // UDP alone, 60-byte frame 0x00..0x3B
    udp_req = 1'b1;
    wait_gnt(src);
    chk("t1_src", src, 1);
    chk("t1_busy", int'(o_busy), 1);
    send_frame(1, 60, 0);
    udp_req = 1'b0;
    repeat (20) tick();
    chk("t1_len", last_run, 60);
    chk("t1_pkt_cnt", int'(o_pkt_cnt), 1);
    chk("t1_busy_after", int'(o_busy), 0);

    // Tie after reset: ARP, UDP, ARP, UDP
    do_reset();
    arp_req = 1'b1; udp_req = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_gnt(src);
      chk("t2_rr_order", src, f % 2);
      send_frame(src, 4, 8'h40 + 16 * f);
    end
    arp_req = 1'b0; udp_req = 1'b0;
    repeat (20) tick();
    chk("t2_pkt_cnt", int'(o_pkt_cnt), 4);

    // UDP granted but never starts: 64 grant cycles, one timeout pulse, ARP after gap
    to0 = n_to;
    udp_req = 1'b1;
    wait_gnt(src);
    chk("t3_src", src, 1);
    arp_req = 1'b1;
    cnt = 1;
    for (int k = 0; k < 200 && o_udp_gnt; k++) begin
      tick();
      if (o_udp_gnt) cnt++;
    end
    chk("t3_gnt_cycles", cnt, 64);
    cnt = 0;
    for (int k = 0; k < 100 && !(o_arp_gnt || o_udp_gnt); k++) begin
      cnt++;
      tick();
    end
    chk("t3_gap_cycles", cnt, 13);
    chk("t3_arp_gnt", int'(o_arp_gnt), 1);
    udp_req = 1'b0;
    send_frame(0, 3, 8'h90);
    arp_req = 1'b0;
    repeat (3) tick();
    chk("t3_timeout_pulses", n_to - to0, 1);
    chk("t3_len", last_run, 3);

    // ARP valid for 1600 cycles: truncated at MAXL
    len0 = n_len;
    repeat (15) tick();
    pkt0 = int'(o_pkt_cnt);
    arp_req = 1'b1;
    wait_gnt(src);
    chk("t4_src", src, 0);
    send_frame(0, 1600, 0);
    chk("t4_gnt_held", int'(o_arp_gnt), 1);
    tick();
    chk("t4_gnt_released", int'(o_arp_gnt), 0);
    arp_req = 1'b0;
    repeat (3) tick();
    chk("t4_len", last_run, MAXL);
    chk("t4_len_pulses", n_len - len0, 1);
    chk("t4_pkt_cnt", int'(o_pkt_cnt), pkt0);

    // ARP toggles vl while ungranted, requests during UDP's gap
    repeat (15) tick();
    udp_req = 1'b1;
    wait_gnt(src);
    chk("t5_src", src, 1);
    for (int i = 0; i < 8; i++) begin
      udp_vl = 1'b1; udp_data = 8'(8'h20 + i);
      exp_q.push_back(8'(8'h20 + i));
      arp_vl = i[0]; arp_data = 8'hEE;
      tick();
    end
    udp_vl = 1'b0; udp_data = 8'h00; udp_req = 1'b0;
    cnt = 0;
    for (int k = 0; k < 100 && !o_arp_gnt; k++) begin
      if (k == 2) arp_req = 1'b1;
      arp_vl = (k < 5) ? ~arp_vl : 1'b0;
      tick();
      if (!o_arp_gnt) cnt++;
    end
    chk("t5_gap_cycles", cnt, 13);
    chk("t5_udp_len", last_run, 8);
    send_frame(0, 2, 8'hA0);
    arp_req = 1'b0;
    repeat (3) tick();
    chk("t5_arp_len", last_run, 2);

    // Async reset in the middle of a frame
    repeat (15) tick();
    to0 = n_to; len0 = n_len;
    udp_req = 1'b1;
    wait_gnt(src);
    for (int i = 0; i < 31; i++) begin
      udp_vl = 1'b1; udp_data = 8'(i);
      exp_q.push_back(8'(i));
      tick();
    end
    chk("t6_pre_tx_en", int'(o_tx_en), 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_tx_en", int'(o_tx_en), 0);
    chk("t6_rst_udp_gnt", int'(o_udp_gnt), 0);
    chk("t6_rst_pkt_cnt", int'(o_pkt_cnt), 0);
    udp_vl = 1'b0; udp_data = 8'h00; udp_req = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    udp_req = 1'b1;
    wait_gnt(src);
    chk("t6_src", src, 1);
    send_frame(1, 10, 8'hC0);
    udp_req = 1'b0;
    repeat (3) tick();
    chk("t6_len", last_run, 10);
    chk("t6_pkt_cnt", int'(o_pkt_cnt), 1);
    chk("t6_no_pulses", (n_to - to0) + (n_len - len0), 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
